// File: rtl/m72_pkg.sv
// Shared types and constants for the M72 main-CPU interrupt controller.
//   pic_init_t : initialisation-word sequencer state (ICW1..ICW4, then READY)
//   pic_req_t  : request handshake state towards the V30
//   PIC_EOI_*  : OCW2 command codes (DIN[7:5]) that the controller acts on
package m72_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        ICW2,
        ICW3,
        ICW4,
        READY
    } pic_init_t;

    typedef enum logic {
        IDLE,
        REQ
    } pic_req_t;

    localparam logic [2:0] PIC_EOI_NS = 3'b001;  // non-specific EOI
    localparam logic [2:0] PIC_EOI_SP = 3'b011;  // specific EOI, level in DIN[2:0]

endpackage

// File: rtl/m72_pic_prio8.sv
// Fixed-priority encoder used by the interrupt controller.
//   req_i   : 8 request bits, bit 0 has the highest priority
//   valid_o : at least one bit of req_i is set
//   idx_o   : index of the lowest set bit (0 when valid_o is low)
module pic_prio8 (
    input  logic [7:0] req_i,
    output logic       valid_o,
    output logic [2:0] idx_o
);

    // Scanning from the top down lets the lowest set index overwrite any
    // higher one, so the last hit is the winner.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise unassigned paths infer latches.
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/m72_pic.sv
// M72 main-CPU interrupt controller, a uPD71059 / 8259-style subset.
// Level sources on IR are edge-detected into IRR, prioritised against the
// mask (IMR) and the in-service levels (ISR, fully nested), and presented to
// the CPU as irq_rq plus an 8-bit vector number held stable until irq_ack.
//
// Ports:
//   CLK_32M, reset_n : clock and asynchronous active-low reset
//   ce               : advance enable; low freezes edge sampling and granting
//   INTCS, IOWR, IORD, A0, DIN : CPU IO bus (chip select, strobes, address, data)
//   DOUT             : registered read data (IRR/ISR at A0=0, IMR at A0=1)
//   IR               : interrupt source levels, rising edge requests service
//   irq_rq, irq_vector, irq_ack : request, vector number and acknowledge
module m72_pic
    import m72_pkg::*;
#(
    parameter int          NUM_IR     = 8,
    parameter logic [7:0]  RESET_BASE = 8'h20
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              INTCS,
    input  logic              IOWR,
    input  logic              IORD,
    input  logic              A0,
    input  logic [7:0]        DIN,
    output logic [7:0]        DOUT,
    input  logic [NUM_IR-1:0] IR,
    output logic              irq_rq,
    output logic [7:0]        irq_vector,
    input  logic              irq_ack
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pic_init_t         init_q, init_d;
    logic              sngl_q, sngl_d;
    logic              ic4_q, ic4_d;
    logic [4:0]        base_q, base_d;
    logic              aeoi_q, aeoi_d;
    logic              read_isr_q, read_isr_d;
    logic [NUM_IR-1:0] imr_q, imr_d;
    logic [NUM_IR-1:0] irr_q, irr_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [NUM_IR-1:0] prev_q, prev_d;
    pic_req_t          req_q, req_d;
    logic [2:0]        sel_q, sel_d;
    logic              irq_rq_q, irq_rq_d;
    logic [7:0]        vec_q, vec_d;
    logic [7:0]        dout_q, dout_d;

    // ------------------------------------------------------------------
    // Bus decode (not gated by ce: the CPU can program while paused)
    // ------------------------------------------------------------------
    logic wr_en, rd_en;
    logic icw1_wr, ocw2_wr, ocw3_wr, data_wr;

    assign wr_en   = IOWR & INTCS;
    assign rd_en   = IORD & INTCS;
    assign icw1_wr = wr_en & ~A0 &  DIN[4];
    assign ocw2_wr = wr_en & ~A0 & ~DIN[4] & ~DIN[3];
    assign ocw3_wr = wr_en & ~A0 & ~DIN[4] &  DIN[3];
    assign data_wr = wr_en &  A0;

    // ------------------------------------------------------------------
    // Priority resolution
    // ------------------------------------------------------------------
    logic       cand_v, lvl_v, eoi_v;
    logic [2:0] cand_n, lvl_n, eoi_n;
    logic       grant_ok;

    pic_prio8 u_cand (
        .req_i   (irr_q & ~imr_q),
        .valid_o (cand_v),
        .idx_o   (cand_n)
    );

    pic_prio8 u_level (
        .req_i   (isr_q),
        .valid_o (lvl_v),
        .idx_o   (lvl_n)
    );

    pic_prio8 u_eoi (
        .req_i   (isr_q),
        .valid_o (eoi_v),
        .idx_o   (eoi_n)
    );

    // Fully nested: a candidate must beat the highest level in service;
    // an equal level stays blocked until it is EOI'd.
    assign grant_ok = cand_v && (!lvl_v || (cand_n < lvl_n));

    // ------------------------------------------------------------------
    // Initialisation sequencer and configuration registers
    // ------------------------------------------------------------------
    always_comb begin
        init_d     = init_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        base_d     = base_q;
        aeoi_d     = aeoi_q;
        imr_d      = imr_q;
        read_isr_d = read_isr_q;

        if (icw1_wr) begin
            init_d     = ICW2;
            sngl_d     = DIN[1];
            ic4_d      = DIN[0];
            imr_d      = '0;
            read_isr_d = 1'b0;
        end else if (data_wr) begin
            unique case (init_q)
                ICW2: begin
                    base_d = DIN[7:3];
                    if (!sngl_q)    init_d = ICW3;
                    else if (ic4_q) init_d = ICW4;
                    else            init_d = READY;
                end
                ICW3: begin
                    // Cascade configuration is meaningless in a single-chip system.
                    init_d = ic4_q ? ICW4 : READY;
                end
                ICW4: begin
                    aeoi_d = DIN[1];
                    init_d = READY;
                end
                READY: imr_d = DIN;
                default: ;  // UNINIT: data-port writes are dropped
            endcase
        end

        if (ocw3_wr && DIN[1]) read_isr_d = DIN[0];
    end

    // ------------------------------------------------------------------
    // Request handshake FSM
    // ------------------------------------------------------------------
    logic ack_take;

    always_comb begin
        req_d    = req_q;
        sel_d    = sel_q;
        irq_rq_d = irq_rq_q;
        vec_d    = vec_q;
        ack_take = 1'b0;

        unique case (req_q)
            IDLE: begin
                if (ce && init_q == READY && grant_ok && !icw1_wr) begin
                    irq_rq_d = 1'b1;
                    vec_d    = {base_q, cand_n};
                    sel_d    = cand_n;
                    req_d    = REQ;
                end
            end
            REQ: begin
                // Vector and sel stay frozen here regardless of new
                // arrivals or mask changes; only ICW1 or ack end the request.
                if (icw1_wr) begin
                    irq_rq_d = 1'b0;
                    req_d    = IDLE;
                end else if (irq_ack) begin
                    ack_take = 1'b1;
                    irq_rq_d = 1'b0;
                    req_d    = IDLE;
                end
            end
            default: req_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // IRR / ISR / edge detector
    // ------------------------------------------------------------------
    always_comb begin
        irr_d  = irr_q;
        isr_d  = isr_q;
        prev_d = prev_q;

        if (icw1_wr) begin
            irr_d = '0;
            isr_d = '0;
        end else begin
            if (ack_take) begin
                irr_d[sel_q] = 1'b0;
                if (!aeoi_q) isr_d[sel_q] = 1'b1;
            end

            if (ocw2_wr && init_q == READY) begin
                if (DIN[7:5] == PIC_EOI_NS) begin
                    if (eoi_v) isr_d[eoi_n] = 1'b0;
                end else if (DIN[7:5] == PIC_EOI_SP) begin
                    isr_d[DIN[2:0]] = 1'b0;
                end
            end

            // Applied after the ack clear so a fresh edge in the ack cycle
            // is not lost.
            if (ce) irr_d = irr_d | (IR & ~prev_q);
        end

        if (ce) prev_d = IR;
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    always_comb begin
        dout_d = 8'hff;
        if (rd_en) begin
            if (A0)              dout_d = imr_q;
            else if (read_isr_q) dout_d = isr_q;
            else                 dout_d = irr_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!reset_n) begin
            init_q     <= UNINIT;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            base_q     <= RESET_BASE[7:3];
            aeoi_q     <= 1'b0;
            read_isr_q <= 1'b0;
            imr_q      <= '1;
            irr_q      <= '0;
            isr_q      <= '0;
            prev_q     <= '0;
            req_q      <= IDLE;
            sel_q      <= 3'd0;
            irq_rq_q   <= 1'b0;
            vec_q      <= RESET_BASE;
            dout_q     <= 8'hff;
        end else begin
            init_q     <= init_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            base_q     <= base_d;
            aeoi_q     <= aeoi_d;
            read_isr_q <= read_isr_d;
            imr_q      <= imr_d;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            prev_q     <= prev_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            irq_rq_q   <= irq_rq_d;
            vec_q      <= vec_d;
            dout_q     <= dout_d;
        end
    end

    assign DOUT       = dout_q;
    assign irq_rq     = irq_rq_q;
    assign irq_vector = vec_q;

endmodule

// File: tb/tb_m72_pic.sv
// Directed self-checking bench for m72_pic. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// produced them.
module tb_m72_pic;

    logic       CLK_32M = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       INTCS;
    logic       IOWR;
    logic       IORD;
    logic       A0;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic [7:0] IR;
    logic       irq_rq;
    logic [7:0] irq_vector;
    logic       irq_ack;

    int errors = 0;
    int checks = 0;

    m72_pic #(.NUM_IR(8), .RESET_BASE(8'h20)) dut (
        .CLK_32M    (CLK_32M),
        .reset_n    (reset_n),
        .ce         (ce),
        .INTCS      (INTCS),
        .IOWR       (IOWR),
        .IORD       (IORD),
        .A0         (A0),
        .DIN        (DIN),
        .DOUT       (DOUT),
        .IR         (IR),
        .irq_rq     (irq_rq),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack)
    );

    always #5 CLK_32M = ~CLK_32M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK_32M);
    endtask

    task automatic io_write(input logic a0, input logic [7:0] d);
        @(negedge CLK_32M);
        INTCS = 1'b1; IOWR = 1'b1; A0 = a0; DIN = d;
        @(negedge CLK_32M);
        INTCS = 1'b0; IOWR = 1'b0;
    endtask

    task automatic io_read(input logic a0, output logic [7:0] d);
        @(negedge CLK_32M);
        INTCS = 1'b1; IORD = 1'b1; A0 = a0;
        @(negedge CLK_32M);
        INTCS = 1'b0; IORD = 1'b0;
        d = DOUT;
    endtask

    task automatic set_ir(input logic [7:0] v);
        @(negedge CLK_32M);
        IR = v;
    endtask

    task automatic ack_pulse();
        @(negedge CLK_32M);
        irq_ack = 1'b1;
        @(negedge CLK_32M);
        irq_ack = 1'b0;
    endtask

    task automatic init_pic(input logic [7:0] icw4);
        io_write(1'b0, 8'h13);
        io_write(1'b1, 8'h20);
        io_write(1'b1, icw4);
        io_write(1'b1, 8'hfa);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL reset_irq_rq: got %b want 0", irq_rq); end
        checks++;
        if (irq_vector !== 8'h20) begin errors++; $display("FAIL reset_vector: got %h want 20", irq_vector); end
        checks++;
        if (DOUT !== 8'hff) begin errors++; $display("FAIL reset_dout: got %h want ff", DOUT); end
        io_write(1'b1, 8'h00);  // data write while UNINIT is dropped
        io_read(1'b1, d);
        checks++;
        if (d !== 8'hff) begin errors++; $display("FAIL reset_imr_uninit: got %h want ff", d); end
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_irr: got %h want 00", d); end
    endtask

    task automatic test_init_and_basic();
        logic [7:0] d;
        init_pic(8'h01);
        io_read(1'b1, d);
        checks++;
        if (d !== 8'hfa) begin errors++; $display("FAIL init_imr: got %h want fa", d); end
        set_ir(8'h01);
        tick(1);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL basic_latency_early: got %b want 0", irq_rq); end
        tick(1);
        checks++;
        if (irq_rq !== 1'b1) begin errors++; $display("FAIL basic_irq_rq: got %b want 1", irq_rq); end
        checks++;
        if (irq_vector !== 8'h20) begin errors++; $display("FAIL basic_vector: got %h want 20", irq_vector); end
        IR = 8'h00;
        ack_pulse();
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL basic_ack_drop: got %b want 0", irq_rq); end
        io_write(1'b0, 8'h0b);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL basic_isr: got %h want 01", d); end
        io_write(1'b0, 8'h0a);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL basic_irr: got %h want 00", d); end
    endtask

    task automatic test_nested();
        logic [7:0] d;
        set_ir(8'h04);
        tick(3);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL nested_blocked: got %b want 0", irq_rq); end
        IR = 8'h00;
        io_write(1'b0, 8'h20);  // non-specific EOI clears ISR0
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL nested_eoi_cycle: got %b want 0", irq_rq); end
        tick(1);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL nested_grant: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        ack_pulse();
        io_write(1'b0, 8'h0b);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h04) begin errors++; $display("FAIL nested_isr: got %h want 04", d); end
        io_write(1'b0, 8'h62);  // specific EOI level 2
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL nested_specific_eoi: got %h want 00", d); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        set_ir(8'h05);
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL simul_first: got rq=%b vec=%h want rq=1 vec=20", irq_rq, irq_vector);
        end
        IR = 8'h00;
        ack_pulse();
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL simul_isr: got %h want 01", d); end
        tick(2);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL simul_blocked: got %b want 0", irq_rq); end
        io_write(1'b0, 8'h20);
        tick(1);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL simul_second: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        ack_pulse();
        io_write(1'b0, 8'h20);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL simul_isr_clear: got %h want 00", d); end
    endtask

    task automatic test_freeze();
        logic [7:0] d;
        set_ir(8'h04);
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL freeze_req: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        set_ir(8'h05);  // higher level arrives while REQ
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL freeze_higher: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        io_write(1'b1, 8'hfe);  // mask sel while REQ
        tick(1);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL freeze_masked: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        IR = 8'h00;
        ack_pulse();
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL freeze_ack_drop: got %b want 0", irq_rq); end
        tick(1);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL freeze_rerequest: got rq=%b vec=%h want rq=1 vec=20", irq_rq, irq_vector);
        end
        ack_pulse();
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL freeze_isr_nested: got %h want 05", d); end
        io_write(1'b0, 8'h20);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h04) begin errors++; $display("FAIL freeze_eoi_ns: got %h want 04", d); end
        io_write(1'b0, 8'h20);
        io_write(1'b1, 8'hfa);
    endtask

    task automatic test_idle_cases();
        logic [7:0] d;
        ack_pulse();
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL idle_ack_rq: got %b want 0", irq_rq); end
        io_write(1'b0, 8'h20);  // EOI with nothing in service
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL idle_isr: got %h want 00", d); end
        @(negedge CLK_32M);
        IORD = 1'b1; INTCS = 1'b0; A0 = 1'b1;
        @(negedge CLK_32M);
        IORD = 1'b0;
        checks++;
        if (DOUT !== 8'hff) begin errors++; $display("FAIL read_unselected: got %h want ff", DOUT); end
    endtask

    task automatic test_aeoi();
        logic [7:0] d;
        init_pic(8'h03);
        io_write(1'b0, 8'h0b);
        set_ir(8'h01);
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL aeoi_req: got rq=%b vec=%h want rq=1 vec=20", irq_rq, irq_vector);
        end
        IR = 8'h00;
        @(negedge CLK_32M);
        irq_ack = 1'b1; IR = 8'h01;  // new edge on sel in the ack cycle
        @(negedge CLK_32M);
        irq_ack = 1'b0;
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL aeoi_ack_drop: got %b want 0", irq_rq); end
        tick(1);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL aeoi_regrant: got rq=%b vec=%h want rq=1 vec=20", irq_rq, irq_vector);
        end
        IR = 8'h00;
        ack_pulse();
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL aeoi_isr: got %h want 00", d); end
    endtask

    task automatic test_ce();
        logic [7:0] d;
        @(negedge CLK_32M);
        ce = 1'b0; IR = 8'h01;
        tick(3);
        IR = 8'h00;
        tick(2);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL ce_paused_rq: got %b want 0", irq_rq); end
        io_write(1'b0, 8'h0a);
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL ce_paused_irr: got %h want 00", d); end
        set_ir(8'h01);
        tick(2);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL ce_held_rq: got %b want 0", irq_rq); end
        @(negedge CLK_32M);
        ce = 1'b1;
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL ce_resume: got rq=%b vec=%h want rq=1 vec=20", irq_rq, irq_vector);
        end
        IR = 8'h00;
        ack_pulse();
    endtask

    task automatic test_icw1_and_reset();
        logic [7:0] d;
        set_ir(8'h01);
        tick(2);
        IR = 8'h00;
        io_write(1'b0, 8'h13);
        checks++;
        if (irq_rq !== 1'b0) begin errors++; $display("FAIL icw1_in_req: got %b want 0", irq_rq); end
        io_read(1'b1, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL icw1_imr_clear: got %h want 00", d); end
        io_write(1'b1, 8'h20);
        io_write(1'b1, 8'h01);
        io_write(1'b1, 8'hfa);
        set_ir(8'h04);
        tick(2);
        checks++;
        if (irq_rq !== 1'b1 || irq_vector !== 8'h22) begin
            errors++; $display("FAIL pre_reset_req: got rq=%b vec=%h want rq=1 vec=22", irq_rq, irq_vector);
        end
        IR = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (irq_rq !== 1'b0 || irq_vector !== 8'h20) begin
            errors++; $display("FAIL midreset_outputs: got rq=%b vec=%h want rq=0 vec=20", irq_rq, irq_vector);
        end
        @(negedge CLK_32M);
        reset_n = 1'b1;
        io_read(1'b1, d);
        checks++;
        if (d !== 8'hff) begin errors++; $display("FAIL midreset_imr: got %h want ff", d); end
        io_read(1'b0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL midreset_irr: got %h want 00", d); end
    endtask

    initial begin
        reset_n = 1'b0;
        ce      = 1'b1;
        INTCS   = 1'b0;
        IOWR    = 1'b0;
        IORD    = 1'b0;
        A0      = 1'b0;
        DIN     = 8'h00;
        IR      = 8'h00;
        irq_ack = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);

        test_reset();
        test_init_and_basic();
        test_nested();
        test_simultaneous();
        test_freeze();
        test_idle_cases();
        test_aeoi();
        test_ce();
        test_icw1_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
